// File: rtl/pcs_tx_ordered_set_ctrl.sv
`default_nettype none
// pcs_tx_ordered_set_ctrl -- 1000BASE-X PCS transmit ordered-set sequencer (GMII to {K,octet}).
// Revision 1.0
module pcs_tx_ordered_set_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             TX_EN,
  input  logic             TX_ER,
  input  logic [7:0]       TXD,
  input  logic             rd_positive,
  output logic [8:0]       tx_code,
  output logic [2:0]       tx_o_set,
  output logic             tx_even,
  output logic [CNT_W-1:0] tx_frame_cnt
);

  localparam logic [8:0] C_K28_5 = 9'h1BC;
  localparam logic [8:0] C_D16_2 = 9'h050;
  localparam logic [8:0] C_D5_6  = 9'h0C5;
  localparam logic [8:0] C_S     = 9'h1FB;
  localparam logic [8:0] C_T     = 9'h1FD;
  localparam logic [8:0] C_R     = 9'h1F7;
  localparam logic [8:0] C_V     = 9'h1FE;

  localparam logic [2:0] C_OS_IDLE = 3'd0;
  localparam logic [2:0] C_OS_S    = 3'd1;
  localparam logic [2:0] C_OS_D    = 3'd2;
  localparam logic [2:0] C_OS_T    = 3'd3;
  localparam logic [2:0] C_OS_R    = 3'd4;
  localparam logic [2:0] C_OS_V    = 3'd5;

  typedef enum logic [2:0] {
    IDLE_K = 3'd0,
    IDLE_D = 3'd1,
    SOP    = 3'd2,
    DATA   = 3'd3,
    EOP_T  = 3'd4,
    EPD_R1 = 3'd5,
    EPD_R2 = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       code_q, code_d;
  logic [2:0]       oset_q, oset_d;
  logic             even_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Outputs are computed for the state being entered, so they align with it.
  always_comb begin
    state_d = state_q;
    code_d  = C_K28_5;
    oset_d  = C_OS_IDLE;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE_K: state_d = IDLE_D;
      IDLE_D: state_d = TX_EN ? SOP : IDLE_K;
      SOP:    state_d = TX_EN ? DATA : EOP_T;
      DATA:   state_d = TX_EN ? DATA : EOP_T;
      EOP_T:  state_d = EPD_R1;
      // A second /R/ is needed only when the first one sits on an even slot.
      EPD_R1: state_d = even_q ? EPD_R2 : IDLE_K;
      EPD_R2: state_d = IDLE_K;
      default: state_d = IDLE_K;
    endcase

    unique case (state_d)
      IDLE_K: begin code_d = C_K28_5; oset_d = C_OS_IDLE; end
      IDLE_D: begin code_d = rd_positive ? C_D5_6 : C_D16_2; oset_d = C_OS_IDLE; end
      SOP:    begin code_d = C_S; oset_d = C_OS_S; end
      DATA: begin
        if (TX_ER) begin
          code_d = C_V;
          oset_d = C_OS_V;
        end else begin
          code_d = {1'b0, TXD};
          oset_d = C_OS_D;
        end
      end
      EOP_T:  begin code_d = C_T; oset_d = C_OS_T; end
      EPD_R1: begin code_d = C_R; oset_d = C_OS_R; end
      EPD_R2: begin code_d = C_R; oset_d = C_OS_R; end
      default: begin code_d = C_K28_5; oset_d = C_OS_IDLE; end
    endcase

    if ((state_d == EOP_T) && (state_q != EOP_T) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE_K;
      code_q  <= C_K28_5;
      oset_q  <= C_OS_IDLE;
      even_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      oset_q  <= oset_d;
      even_q  <= ~even_q;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_code      = code_q;
  assign tx_o_set     = oset_q;
  assign tx_even      = even_q;
  assign tx_frame_cnt = cnt_q;

endmodule
`default_nettype wire
